// File: rtl/idct1d_pkg.sv
// Shared widths, state encoding and clamp limits for the 1-D approximate inverse DCT.
package idct1d_pkg;

  localparam int unsigned DW = 16;
  localparam int unsigned AW = 6;
  localparam int unsigned IW = DW + 3;

  localparam int unsigned READ_CYCLES  = 9;
  localparam int unsigned WRITE_CYCLES = 8;

  localparam int CLAMP_MIN = -256;
  localparam int CLAMP_MAX = 255;

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StS1    = 3'd2;
  localparam logic [2:0] StS2    = 3'd3;
  localparam logic [2:0] StS3    = 3'd4;
  localparam logic [2:0] StWrite = 3'd5;

  typedef logic signed [IW-1:0] word_t;
  typedef word_t [7:0] vec_t;

endpackage

// File: rtl/idct1d_butterfly.sv
// Combinational inverse butterfly: next value of the 8 working registers for S1, S2 and S3.
module idct1d_butterfly
  import idct1d_pkg::*;
(
  input  logic [2:0] state_i,
  input  vec_t       r_i,
  output vec_t       r_o
);

  always_comb begin
    r_o = r_i;
    unique case (state_i)
      StS1: begin
        r_o[0] = r_i[0] + r_i[4];
        r_o[1] = r_i[0] - r_i[4];
        r_o[2] = r_i[6] <<< 1;
        r_o[3] = -(r_i[2] <<< 1);
        r_o[4] = r_i[7] <<< 1;
        r_o[5] = r_i[3] <<< 1;
        r_o[6] = r_i[5] - r_i[1];
        r_o[7] = -r_i[1] - r_i[5];
      end
      StS2: begin
        r_o[0] = r_i[0] - r_i[3];
        r_o[3] = r_i[0] + r_i[3];
        r_o[1] = r_i[1] - r_i[2];
        r_o[2] = r_i[1] + r_i[2];
        r_o[4] = r_i[4] <<< 1;
        r_o[5] = r_i[5] <<< 1;
        r_o[6] = r_i[6] <<< 1;
        r_o[7] = r_i[7] <<< 1;
      end
      StS3: begin
        r_o[0] = r_i[0] - r_i[7];
        r_o[7] = r_i[0] + r_i[7];
        r_o[1] = r_i[1] - r_i[6];
        r_o[6] = r_i[1] + r_i[6];
        r_o[2] = r_i[2] - r_i[5];
        r_o[5] = r_i[2] + r_i[5];
        r_o[3] = r_i[3] - r_i[4];
        r_o[4] = r_i[3] + r_i[4];
      end
      default: r_o = r_i;
    endcase
  end

endmodule

// File: rtl/idct1d.sv
// 1-D approximate inverse DCT over a shared registered-address RAM (read 8, transform, write 8).
// Build option: define IDCT1D_CLAMP_EN to saturate written samples to [-256, 255].
module idct1d
  import idct1d_pkg::*;
(
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          en_i,
  output logic          rdy_o,
  input  logic [AW-1:0] rstart_i,
  input  logic [AW-1:0] wstart_i,
  input  logic [AW-1:0] stride_i,
  output logic [AW-1:0] addr_o,
  output logic          wren_o,
  output logic [DW-1:0] data_o,
  input  logic [DW-1:0] q_i
);

  logic [2:0]    state_q, state_d;
  logic [3:0]    cycle_q, cycle_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] wstart_q, wstart_d;
  logic [AW-1:0] stride_q, stride_d;
  vec_t          r_q, r_d, bfly;

  idct1d_butterfly u_bfly (
    .state_i (state_q),
    .r_i     (r_q),
    .r_o     (bfly)
  );

  always_comb begin
    state_d  = state_q;
    cycle_d  = cycle_q;
    addr_d   = addr_q;
    wstart_d = wstart_q;
    stride_d = stride_q;
    r_d      = r_q;
    case (state_q)
      StIdle: begin
        cycle_d = '0;
        if (en_i) begin
          wstart_d = wstart_i;
          stride_d = stride_i;
          addr_d   = rstart_i;
          state_d  = StRead;
        end
      end
      StRead: begin
        // Shift in every cycle: the first (stale) word falls out after nine shifts.
        r_d     = {word_t'({{(IW-DW){q_i[DW-1]}}, q_i}), r_q[7:1]};
        addr_d  = addr_q + stride_q;
        cycle_d = cycle_q + 4'd1;
        if (cycle_q == 4'(READ_CYCLES - 1)) state_d = StS1;
      end
      StS1: begin
        r_d     = bfly;
        state_d = StS2;
      end
      StS2: begin
        r_d     = bfly;
        state_d = StS3;
      end
      StS3: begin
        r_d     = bfly;
        addr_d  = wstart_q;
        cycle_d = '0;
        state_d = StWrite;
      end
      StWrite: begin
        addr_d  = addr_q + stride_q;
        cycle_d = cycle_q + 4'd1;
        if (cycle_q == 4'(WRITE_CYCLES - 1)) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      cycle_q  <= '0;
      addr_q   <= '0;
      wstart_q <= '0;
      stride_q <= '0;
      r_q      <= '0;
    end else begin
      state_q  <= state_d;
      cycle_q  <= cycle_d;
      addr_q   <= addr_d;
      wstart_q <= wstart_d;
      stride_q <= stride_d;
      r_q      <= r_d;
    end
  end

  assign rdy_o  = (state_q == StIdle);
  assign addr_o = addr_q;

`ifdef IDCT1D_CLAMP_EN
  word_t wr_shift;
  always_comb begin
    wren_o   = (state_q == StWrite);
    wr_shift = r_q[cycle_q[2:0]] >>> 3;
    data_o   = '0;
    if (wren_o) begin
      if (wr_shift < IW'(CLAMP_MIN))      data_o = DW'(CLAMP_MIN);
      else if (wr_shift > IW'(CLAMP_MAX)) data_o = DW'(CLAMP_MAX);
      else                                data_o = wr_shift[DW-1:0];
    end
  end
`else
  always_comb begin
    wren_o = (state_q == StWrite);
    data_o = '0;
    if (wren_o) data_o = r_q[cycle_q[2:0]][DW+2:3];
  end
`endif

endmodule

// File: tb/tb_idct1d.sv
// Scoreboard bench for idct1d: RAM model, matrix reference model and forward-DCT round trips.
module tb_idct1d;

  logic        clk = 1'b0;
  logic        reset, en, rdy, wren;
  logic [5:0]  rstart, wstart, stride, addr;
  logic [15:0] data, q;

  logic [15:0] ram [64];
  logic        pl_we;
  logic [5:0]  pl_addr;
  logic [15:0] pl_data;

  typedef struct packed { logic [5:0] a; logic [15:0] d; } wr_t;
  wr_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int y_vec[8];
  int exp_vec[8];

  // x_k = sum_j M[k][j] * y_j, the closed form of the three inverse stages.
  localparam int M [8][8] = '{
    '{1,  2,  2,  0,  1,  2,  0,  0},
    '{1,  2,  0,  0, -1, -2, -2,  0},
    '{1,  0,  0, -4, -1,  0,  2,  0},
    '{1,  0, -2,  0,  1,  0,  0, -4},
    '{1,  0, -2,  0,  1,  0,  0,  4},
    '{1,  0,  0,  4, -1,  0,  2,  0},
    '{1, -2,  0,  0, -1,  2, -2,  0},
    '{1, -2,  2,  0,  1, -2,  0,  0}};

  always #5 clk = ~clk;

  idct1d u_dut (
    .clk_i    (clk),
    .reset_i  (reset),
    .en_i     (en),
    .rdy_o    (rdy),
    .rstart_i (rstart),
    .wstart_i (wstart),
    .stride_i (stride),
    .addr_o   (addr),
    .wren_o   (wren),
    .data_o   (data),
    .q_i      (q)
  );

  always @(posedge clk) begin
    if (pl_we) ram[pl_addr] <= pl_data;
    else if (wren) ram[addr] <= data;
    q <= ram[addr];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write", addr, data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr), 32'(e.a));
        check("wr_data", 32'(data), 32'(e.d));
      end
    end
  end

  function automatic int out_sample(input int x);
    int v = x >>> 3;
`ifdef IDCT1D_CLAMP_EN
    if (v < -256) v = -256;
    else if (v > 255) v = 255;
`endif
    return v;
  endfunction

  function automatic int wrap(input logic [5:0] base, input logic [5:0] st, input int j);
    return (int'(base) + j * int'(st)) % 64;
  endfunction

  task automatic poke(input int a, input logic [15:0] d);
    pl_we = 1'b1;
    pl_addr = 6'(a);
    pl_data = d;
    @(posedge clk);
    #1 pl_we = 1'b0;
  endtask

  task automatic load_y(input logic [5:0] rs, input logic [5:0] st);
    for (int j = 0; j < 8; j++) poke(wrap(rs, st, j), 16'(y_vec[j]));
  endtask

  // Reference: use whatever the RAM really holds at the read addresses.
  task automatic model_from_ram(input logic [5:0] rs, input logic [5:0] st);
    int yy[8];
    int x;
    for (int j = 0; j < 8; j++) yy[j] = int'($signed(ram[wrap(rs, st, j)]));
    for (int k = 0; k < 8; k++) begin
      x = 0;
      for (int j = 0; j < 8; j++) x += M[k][j] * yy[j];
      exp_vec[k] = out_sample(x);
    end
  endtask

  task automatic fdct(input int s[8]);
    y_vec[0] = s[0] + s[1] + s[2] + s[3] + s[4] + s[5] + s[6] + s[7];
    y_vec[1] = s[0] - s[7] + s[1] - s[6];
    y_vec[2] = s[0] + s[7] - s[3] - s[4];
    y_vec[3] = s[5] - s[2];
    y_vec[4] = s[0] + s[7] + s[3] + s[4] - s[1] - s[6] - s[2] - s[5];
    y_vec[5] = s[0] - s[7] - s[1] + s[6];
    y_vec[6] = s[2] + s[5] - s[1] - s[6];
    y_vec[7] = s[4] - s[3];
  endtask

  task automatic push_exp(input logic [5:0] ws, input logic [5:0] st);
    wr_t e;
    for (int k = 0; k < 8; k++) begin
      e.a = 6'(wrap(ws, st, k));
      e.d = 16'(exp_vec[k]);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_op(input logic [5:0] rs, input logic [5:0] ws, input logic [5:0] st);
    @(negedge clk);
    check("rdy_before_op", 32'(rdy), 32'd1);
    en = 1'b1;
    rstart = rs;
    wstart = ws;
    stride = st;
    @(posedge clk);
    #1;
    en = 1'b0;
    rstart = 6'($urandom);
    wstart = 6'($urandom);
    stride = 6'($urandom);
  endtask

  task automatic finish_op(input string nm);
    int cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (rdy !== 1'b1 && cnt < 40);
    check({nm, "_latency"}, 32'(cnt), 32'd21);
    check({nm, "_drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic model_op(input string nm, input logic [5:0] rs, input logic [5:0] ws,
                          input logic [5:0] st);
    load_y(rs, st);
    model_from_ram(rs, st);
    push_exp(ws, st);
    start_op(rs, ws, st);
    finish_op(nm);
  endtask

  initial begin
    int s[8];
    int cnt, rdy_hits, rdy_at;
    logic [5:0] rs, ws, st;
    logic [15:0] old19;

    reset = 1'b1; en = 1'b0; rstart = '0; wstart = '0; stride = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < 64; i++) poke(i, 16'h0000);
    @(negedge clk);
    check("reset_rdy", 32'(rdy), 32'd1);
    check("reset_addr", 32'(addr), 32'd0);
    check("reset_wren", 32'(wren), 32'd0);
    check("reset_data", 32'(data), 32'd0);
    reset = 1'b0;

    // DC: 64 in y0 gives 8 everywhere.
    y_vec = '{64, 0, 0, 0, 0, 0, 0, 0};
    load_y(6'd0, 6'd1);
    exp_vec = '{8, 8, 8, 8, 8, 8, 8, 8};
    push_exp(6'd0, 6'd1);
    start_op(6'd0, 6'd0, 6'd1);
    finish_op("dc");

    // Fixed round trip example.
    y_vec = '{10, 10, 10, 0, 10, 10, 0, 0};
    load_y(6'd0, 6'd1);
    exp_vec = '{10, 0, 0, 0, 0, 0, 0, 0};
    push_exp(6'd0, 6'd1);
    start_op(6'd0, 6'd0, 6'd1);
    finish_op("rt_fixed");

    // Clamp boundary, both signs.
`ifdef IDCT1D_CLAMP_EN
    exp_vec = '{255, 255, 255, 255, 255, 255, 255, 255};
`else
    exp_vec = '{500, 500, 500, 500, 500, 500, 500, 500};
`endif
    y_vec = '{4000, 0, 0, 0, 0, 0, 0, 0};
    load_y(6'd8, 6'd1);
    push_exp(6'd16, 6'd1);
    start_op(6'd8, 6'd16, 6'd1);
    finish_op("clamp_pos");
`ifdef IDCT1D_CLAMP_EN
    exp_vec = '{-256, -256, -256, -256, -256, -256, -256, -256};
`else
    exp_vec = '{-500, -500, -500, -500, -500, -500, -500, -500};
`endif
    y_vec = '{-4000, 0, 0, 0, 0, 0, 0, 0};
    load_y(6'd8, 6'd1);
    push_exp(6'd16, 6'd1);
    start_op(6'd8, 6'd16, 6'd1);
    finish_op("clamp_neg");

    // Column stride with wrap-around.
    for (int j = 0; j < 8; j++) y_vec[j] = int'($urandom_range(4000)) - 2000;
    model_op("col_wrap", 6'h3C, 6'h3C, 6'd8);

    // Stride zero: every access on one address.
    for (int j = 0; j < 8; j++) y_vec[j] = int'($urandom_range(2000)) - 1000;
    model_op("stride0", 6'd5, 6'd5, 6'd0);

    // Random coefficients against the matrix model.
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 8; j++) y_vec[j] = int'($urandom_range(8000)) - 4000;
      model_op("rand_coef", 6'($urandom), 6'($urandom), 6'($urandom));
    end

    // Random forward-DCT round trips must return the samples bit-exactly.
    for (int t = 0; t < 6; t++) begin
      for (int j = 0; j < 8; j++) s[j] = int'($urandom_range(511)) - 256;
      fdct(s);
      rs = 6'($urandom);
      ws = 6'($urandom);
      st = 6'($urandom) | 6'd1;
      load_y(rs, st);
      exp_vec = s;
      push_exp(ws, st);
      start_op(rs, ws, st);
      finish_op("round_trip");
    end

    // Reset during WRITE cycle 3: three words land, the fourth never does.
    for (int j = 0; j < 8; j++) y_vec[j] = int'($urandom_range(2000)) - 1000;
    load_y(6'd0, 6'd1);
    poke(19, 16'hA5A5);
    old19 = ram[19];
    model_from_ram(6'd0, 6'd1);
    push_exp(6'd16, 6'd1);
    start_op(6'd0, 6'd16, 6'd1);
    repeat (15) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort_wren", 32'(wren), 32'd0);
    check("abort_data", 32'(data), 32'd0);
    check("abort_rdy", 32'(rdy), 32'd1);
    check("abort_addr", 32'(addr), 32'd0);
    check("abort_pending", 32'(exp_q.size()), 32'd5);
    exp_q.delete();
    check("abort_ram18", 32'(ram[18]), 32'(16'(exp_vec[2])));
    check("abort_ram19", 32'(ram[19]), 32'(old19));
    reset = 1'b0;
    for (int j = 0; j < 8; j++) y_vec[j] = int'($urandom_range(2000)) - 1000;
    model_op("after_abort", 6'd40, 6'd48, 6'd1);

    // en held high: two back-to-back operations, one IDLE cycle between.
    for (int j = 0; j < 8; j++) y_vec[j] = int'($urandom_range(2000)) - 1000;
    load_y(6'd0, 6'd1);
    model_from_ram(6'd0, 6'd1);
    push_exp(6'd32, 6'd1);
    push_exp(6'd32, 6'd1);
    start_op(6'd0, 6'd32, 6'd1);
    en = 1'b1;
    rstart = 6'd0; wstart = 6'd32; stride = 6'd1;
    rdy_hits = 0;
    rdy_at = 0;
    for (int i = 1; i <= 41; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) begin
        rdy_hits++;
        rdy_at = i;
      end
    end
    en = 1'b0;
    check("b2b_idle_cycles", 32'(rdy_hits), 32'd1);
    check("b2b_idle_at", 32'(rdy_at), 32'd21);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (rdy !== 1'b1 && cnt < 40);
    check("b2b_second_done", 32'(cnt), 32'd1);
    check("b2b_drain", 32'(exp_q.size()), 32'd0);

    // en pulsed while busy is ignored.
    for (int j = 0; j < 8; j++) y_vec[j] = int'($urandom_range(2000)) - 1000;
    load_y(6'd20, 6'd1);
    model_from_ram(6'd20, 6'd1);
    push_exp(6'd50, 6'd1);
    start_op(6'd20, 6'd50, 6'd1);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
      if (cnt == 5) begin
        en = 1'b1;
        rstart = 6'd1; wstart = 6'd2; stride = 6'd3;
      end
      if (cnt == 6) en = 1'b0;
    end while (rdy !== 1'b1 && cnt < 40);
    check("busy_en_latency", 32'(cnt), 32'd21);
    rdy_hits = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (rdy === 1'b1) rdy_hits++;
    end
    check("busy_en_stays_idle", 32'(rdy_hits), 32'd25);
    check("busy_en_drain", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/idct1d.md
Name: idct1d

Overview:
- Inverse of the team's approximate 1-D DCT: reads 8 coefficients from the shared 64-word block RAM, runs three inverse butterfly stages and writes 8 reconstructed samples back.
- Used twice per 8x8 block by the MPEG2 decoder controller: stride 1 for rows, stride 8 for columns.
- Exact inverse of the forward approximate DCT whenever the forward pass did not overflow.

Parameters:
- DW, 16, RAM data width (signed two's complement)
- AW, 6, RAM address width
- IW, 19, internal datapath width (DW+3)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  start request, sampled only while rdy=1
- rdy  out  1  high in IDLE only
- rstart  in  AW  first read address
- wstart  in  AW  first write address
- stride  in  AW  address increment for both reads and writes
- addr  out  AW  registered RAM address
- wren  out  1  RAM write enable
- data  out  DW  RAM write data
- q  in  DW  RAM read data

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- While reset=1: state=IDLE, addr=0, cycle=0, all internal registers=0, wren=0, data=0, rdy=1. Asserting reset mid-operation aborts the operation and deasserts wren immediately; no partial recovery.
- RAM timing: q reflects the address on addr one cycle later (registered-address RAM). Writes commit on the clk edge while wren=1.
- IDLE: rdy=1. On en=1, latch wstart and stride, set addr=rstart, cycle=0, go to READ.
- READ, 9 cycles:
  - Capture in cycle 0 is discarded (pipeline fill); cycles 1..8 capture y0..y7, sign-extended to IW.
  - addr += stride every cycle, modulo 2^AW.
  - After cycle 8, go to S1.
- S1:
  - b0=y0+y4, b1=y0-y4, b2=2*y6, b3=-2*y2
  - b4=2*y7, b5=2*y3, b6=y5-y1, b7=-y1-y5
- S2:
  - a0=b0-b3, a3=b0+b3, a1=b1-b2, a2=b1+b2
  - a4..a7 = 2*b4..2*b7
- S3:
  - x0=a0-a7, x7=a0+a7, x1=a1-a6, x6=a1+a6, x2=a2-a5, x5=a2+a5, x3=a3-a4, x4=a3+a4
  - set addr=saved wstart, cycle=0, go to WRITE.
- Arithmetic: all IW-bit two's complement; no overflow is possible for DW-bit inputs.
- WRITE, cycles 0..7:
  - wren=1; data = sample k arithmetic-shifted right by 3, then truncated to DW.
  - addr += saved stride each cycle, wrapping modulo 2^AW.
  - After cycle 7, go to IDLE.
- Latency: en accepted in cycle T; READ occupies T+1..T+9, S1..S3 occupy T+10..T+12, WRITE occupies T+13..T+20; rdy=1 again at T+21. en may be asserted in that cycle for back-to-back operation.
- rstart, wstart and stride changes outside IDLE are ignored.
- stride=0 is legal: all reads and writes hit one address.
- Unused state encodings go to IDLE.
- wren and data are combinational from state and cycle; data=0 whenever wren=0.

Optional Feature:
- Macro IDCT1D_CLAMP_EN.
- Defined: each shifted sample is saturated to [-256, 255] (MPEG2 IDCT output range) before it is written.
- Undefined: plain truncation to DW bits, with no saturation logic.

Decomposition:
- Package idct1d_pkg holds:
  - state encoding (IDLE, READ, S1, S2, S3, WRITE, 3 bits)
  - DW, AW, IW
  - READ_CYCLES=9, WRITE_CYCLES=8
  - CLAMP_MIN=-256, CLAMP_MAX=255
- One natural sub-module, idct1d_butterfly: purely combinational, selects and computes the next values of the 8 registers for S1/S2/S3. The top level keeps the FSM, address generation and RAM port.

Test Plan:
- DC: RAM[0]=64, RAM[1..7]=0, rstart=wstart=0, stride=1 -> RAM[0..7]=8 each; rdy returns exactly 21 cycles after en.
- Round trip: RAM[0..7]=[10,10,10,0,10,10,0,0] -> RAM[0..7]=[10,0,0,0,0,0,0,0]; random 8-vectors run through a forward-DCT model then idct1d must return the original values bit-exactly.
- Column stride with wrap: rstart=wstart=0x3C, stride=8 -> accesses 0x3C,0x04,0x0C,...,0x34 (mod 64); no other address is written.
- Clamp: y0=4000, others 0 -> 500 written when the macro is undefined, 255 when IDCT1D_CLAMP_EN is defined; y0=-4000 -> -500 or -256 respectively.
- Reset at WRITE cycle 3 -> wren drops in the same cycle, only 3 words written, rdy=1 and addr=0 after reset; a following en with new arguments completes correctly.
- en held high continuously -> back-to-back operations with exactly one IDLE cycle between them; en pulsed while busy -> ignored, no second operation.
